// File: rtl/apb_pkg.sv
// Shared types for the APB requester slice.
//   apb_req_state_e : requester FSM states
//   APB_WRITE/READ  : values carried on the wr_rd direction signal
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_req_state_e;

    localparam logic APB_WRITE = 1'b1;
    localparam logic APB_READ  = 1'b0;

endpackage

// File: rtl/apb_req_timer.sv
// ACCESS-phase wait counter for the APB requester.
//   clk, rst   : clock, asynchronous active-high reset
//   clr_i      : restart the count (issued in SETUP)
//   inc_i      : one more wait state seen (ready=0 in ACCESS)
//   expired_o  : the current wait cycle is the last one allowed;
//                never asserted when TIMEOUT_CYCLES is 0
module apb_req_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int unsigned CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Saturating increment: with the timeout disabled the count just parks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (TIMEOUT_CYCLES != 0) && (cnt_q == LAST);

endmodule

// File: rtl/apb_requester.sv
// APB initiator: takes one command at a time from a valid/ready client channel,
// runs SETUP/ACCESS on APB (honouring wait states, with optional timeout) and
// returns read data / error status on a valid/ready response channel.
//   clk, rst                       : clock, asynchronous active-high reset
//   cmd_valid/ready, cmd_*         : command channel (direction, address, data, strobes)
//   rsp_valid/ready, rsp_rdata/err : response channel (err = timed out)
//   addr, sel, enable, wr_rd,
//   wdata, wstrobe, ready, rdata   : APB requester-side bus
module apb_requester
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 5,
    parameter int unsigned WDATA_WIDTH    = 32,
    parameter int unsigned RDATA_WIDTH    = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    localparam int unsigned STRB_WIDTH    = WDATA_WIDTH / 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_wr_rd,
    input  logic [ADDR_WIDTH-1:0]  cmd_addr,
    input  logic [WDATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0]  cmd_wstrobe,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [RDATA_WIDTH-1:0] rsp_rdata,
    output logic                   rsp_err,
    output logic [ADDR_WIDTH-1:0]  addr,
    output logic                   sel,
    output logic                   enable,
    output logic                   wr_rd,
    output logic [WDATA_WIDTH-1:0] wdata,
    output logic [STRB_WIDTH-1:0]  wstrobe,
    input  logic                   ready,
    input  logic [RDATA_WIDTH-1:0] rdata
);

    apb_req_state_e         state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   sel_q, sel_d;
    logic                   enable_q, enable_d;
    logic                   wr_rd_q, wr_rd_d;
    logic [WDATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]  wstrobe_q, wstrobe_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [RDATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                   rsp_err_q, rsp_err_d;

    logic tmr_clr, tmr_inc, tmr_expired;

    apb_req_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (tmr_clr),
        .inc_i     (tmr_inc),
        .expired_o (tmr_expired)
    );

    assign cmd_ready = (state_q == IDLE) && !rst;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        sel_d       = sel_q;
        enable_d    = enable_q;
        wr_rd_d     = wr_rd_q;
        wdata_d     = wdata_q;
        wstrobe_d   = wstrobe_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        tmr_clr     = 1'b0;
        tmr_inc     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d    = cmd_addr;
                    wr_rd_d   = cmd_wr_rd;
                    wdata_d   = cmd_wdata;
                    wstrobe_d = (cmd_wr_rd == APB_WRITE) ? cmd_wstrobe : '0;
                    sel_d     = 1'b1;
                    enable_d  = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                enable_d = 1'b1;
                tmr_clr  = 1'b1;
                state_d  = ACCESS;
            end
            ACCESS: begin
                if (ready) begin
                    sel_d       = 1'b0;
                    enable_d    = 1'b0;
                    wstrobe_d   = '0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = (wr_rd_q == APB_WRITE) ? '0 : rdata;
                    state_d     = RESP;
                end else begin
                    tmr_inc = 1'b1;
                    // expired reflects the count before this increment, so
                    // ACCESS lasts exactly TIMEOUT_CYCLES cycles.
                    if (tmr_expired) begin
                        sel_d       = 1'b0;
                        enable_d    = 1'b0;
                        wstrobe_d   = '0;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                        state_d     = RESP;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            sel_q       <= 1'b0;
            enable_q    <= 1'b0;
            wr_rd_q     <= 1'b0;
            wdata_q     <= '0;
            wstrobe_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            sel_q       <= sel_d;
            enable_q    <= enable_d;
            wr_rd_q     <= wr_rd_d;
            wdata_q     <= wdata_d;
            wstrobe_q   <= wstrobe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign addr      = addr_q;
    assign sel       = sel_q;
    assign enable    = enable_q;
    assign wr_rd     = wr_rd_q;
    assign wdata     = wdata_q;
    assign wstrobe   = wstrobe_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
